direct_mapped_cache: RTL and testbench
======================================

DIRECT_MAPPED_CACHE -- requirements
Module: direct_mapped_cache

Interface
REQ-001 SHALL have parameter LINES, default 32, number of one-word lines (power of two, 2..128).
REQ-002 SHALL have parameter RAM_LAT, default 2, cycles each RAM access is held (>=1).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, CPU request present.
REQ-006 SHALL have port req_write, input, 1, 1=write, 0=read.
REQ-007 SHALL have port req_addr, input, [0:31], word address; only addr % 4096 is significant.
REQ-008 SHALL have port req_data, input, [0:31], write data.
REQ-009 SHALL have port req_ready, output, 1, request accepted on the edge where req_valid and req_ready are both high.
REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resp_data, output, [0:31], read data, or echoed write data.
REQ-012 SHALL have port ram_address, output, [0:31], drives the downstream ram address input.
REQ-013 SHALL have port ram_data, output, [0:31], drives the ram data input.
REQ-014 SHALL have port ram_write, output, 1, drives the ram write input.
REQ-015 SHALL have port ram_out, input, [0:31], ram read data.

Function
REQ-016 SHALL split the effective address A = req_addr % 4096 into index = A % LINES and tag = A / LINES; per line, store a valid bit, the tag and a 32-bit data word.
REQ-017 SHALL implement FSM states IDLE, RD_MISS, WR_THRU, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 On accept: read hit -> RESP; read miss -> RD_MISS; write (hit or miss) -> WR_THRU.
REQ-019 In RD_MISS, SHALL drive ram_address=A and ram_write=0 for RAM_LAT cycles; on the last edge SHALL capture ram_out into the line, set valid, set the tag and go to RESP.
REQ-020 In WR_THRU (write-through, write-allocate), SHALL drive ram_address=A, ram_data=req_data and ram_write=1 for RAM_LAT cycles; on the last edge SHALL update the line (valid, tag, data) and go to RESP.
REQ-021 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE.
REQ-022 Latency from accept edge to the resp_valid cycle: hit 1 cycle; miss or write RAM_LAT+1 cycles.
REQ-023 Request fields SHALL be registered at accept; input changes after accept SHALL be ignored.
REQ-024 Outside RD_MISS/WR_THRU, ram_write SHALL be 0; ram_address/ram_data SHALL hold their last values.
REQ-025 A conflict miss (same index, different tag) SHALL replace the line; there is no dirty state.
REQ-026 Addresses equal modulo 4096 SHALL alias to the same line and tag.

Reset
REQ-027 When rst_n=0, SHALL immediately set state=IDLE, clear all valid bits, and drive resp_valid=0, ram_write=0, resp_data=0, ram_address=0, ram_data=0.
REQ-028 Reset during RD_MISS/WR_THRU SHALL abort the access with no response and no line update; ram_write SHALL drop asynchronously.
REQ-029 req_ready SHALL be 1 on the first cycle after rst_n deasserts.

Configuration
REQ-030 With CACHE_STATS_EN defined, SHALL add outputs hit_count and miss_count, 16-bit each, reset to 0 and saturating at 65535; they count read hits and read misses only.
REQ-031 Without CACHE_STATS_EN, these ports and their logic SHALL be absent, with no other behaviour change.

Verification
REQ-032 Write A=0, D=14528 -> ram_write=1 for 2 cycles at ram_address 0; resp_valid 3 cycles after accept, resp_data=14528.
REQ-033 Then read A=0 -> hit: resp_data=14528 one cycle after accept; ram_write stays 0.
REQ-034 Write 2816867292, D=526421; then read 3036 -> hit via alias, resp_data=526421.
REQ-035 Read 3068 (index 28, same as 3036), with the RAM holding 7 -> miss: ram_address=3068, resp_data=7; a following read of 3036 misses.
REQ-036 Assert rst_n=0 in the middle of a write to 2001 -> ram_write drops immediately; a later read of 2001 is a miss.
REQ-037 With CACHE_STATS_EN defined, the scenario of REQ-032 to REQ-035 -> hit_count=2, miss_count=2.

Source files
------------

// File: rtl/direct_mapped_cache.sv
// ============================================================================
// Module   : direct_mapped_cache
// Purpose  : One-word-per-line direct-mapped cache, write-through with
//            write-allocate, in front of a fixed-latency RAM. The effective
//            address is the low 12 bits of the word address.
// Options  : define CACHE_STATS_EN to add saturating read hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module direct_mapped_cache #(
    parameter int LINES   = 32,
    parameter int RAM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_write,
    input  logic [31:0] ram_out
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 12 - IDX_W;
    localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(RAM_LAT - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RD_MISS = 2'd1;
    localparam logic [1:0] c_WR_THRU = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [11:0]      r_eff;
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_line [LINES];

    logic [11:0]      w_eff;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_accept;
    logic [IDX_W-1:0] w_r_idx;
    logic [TAG_W-1:0] w_r_tag;
    logic             w_in_access;
    logic             w_fill;
    logic [31:0]      w_fill_data;
    logic             w_unused_addr;

    // Only the low 12 address bits select a line; the rest alias.
    assign w_eff         = req_addr[11:0];
    assign w_unused_addr = &{1'b0, req_addr[31:12]};
    assign w_idx         = w_eff[IDX_W-1:0];
    assign w_tag         = w_eff[11:IDX_W];
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_accept      = req_valid && (r_state == c_IDLE);
    assign req_ready     = (r_state == c_IDLE);

    assign w_r_idx     = r_eff[IDX_W-1:0];
    assign w_r_tag     = r_eff[11:IDX_W];
    assign w_in_access = (r_state == c_RD_MISS) || (r_state == c_WR_THRU);
    assign w_fill      = w_in_access && (r_cnt == c_LAST);
    // Writes allocate with the held write data; read misses take the RAM word.
    assign w_fill_data = (r_state == c_WR_THRU) ? ram_data : ram_out;

    // Control FSM, RAM interface registers, response registers and valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_eff       <= '0;
            r_valid     <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_write   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_eff <= w_eff;
                        r_cnt <= '0;
                        if (req_write) begin
                            r_state     <= c_WR_THRU;
                            ram_address <= {20'd0, w_eff};
                            ram_data    <= req_data;
                            ram_write   <= 1'b1;
                        end else if (w_hit) begin
                            r_state    <= c_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= r_line[w_idx];
                        end else begin
                            r_state     <= c_RD_MISS;
                            ram_address <= {20'd0, w_eff};
                        end
                    end
                end
                c_RD_MISS, c_WR_THRU: begin
                    if (r_cnt == c_LAST) begin
                        r_state          <= c_RESP;
                        resp_valid       <= 1'b1;
                        resp_data        <= w_fill_data;
                        ram_write        <= 1'b0;
                        r_valid[w_r_idx] <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Tag and data storage; contents are meaningless while the valid bit is 0,
    // so an aborted fill leaves no visible trace.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_r_idx]  <= w_r_tag;
            r_line[w_r_idx] <= w_fill_data;
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating counters of read hits and read misses, sampled at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (w_accept && !req_write) begin
            if (w_hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_direct_mapped_cache.sv
// ============================================================================
// Module   : tb_direct_mapped_cache
// Purpose  : Directed self-checking bench for direct_mapped_cache with a
//            behavioural RAM. Define CACHE_STATS_EN to check the counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_direct_mapped_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [31:0] ram_address;
    logic [31:0] ram_data;
    logic        ram_write;
    logic [31:0] ram_out;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [4096];

    always #5 clk = ~clk;

    direct_mapped_cache #(.LINES(32), .RAM_LAT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_write   (ram_write),
        .ram_out     (ram_out)
`ifdef CACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    // Behavioural RAM: combinational read, write on the rising edge.
    assign ram_out = mem[ram_address[11:0]];
    always @(posedge clk) begin
        if (ram_write) mem[ram_address[11:0]] <= ram_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One request: lat = cycles from accept edge to resp_valid (99 on timeout),
    // wcyc = cycles with ram_write high, raddr = last ram_address seen.
    task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        output int lat, output logic [31:0] rdata,
                        output int wcyc, output logic [31:0] raddr);
        logic got;
        got   = 1'b0;
        lat   = 0;
        wcyc  = 0;
        raddr = '0;
        rdata = '0;
        @(negedge clk);
        chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_data  = data;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the DUT must have registered them.
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 32'hFFFF_FFFF;
        req_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) begin
            lat++;
            if (resp_valid) begin
                rdata = resp_data;
                got   = 1'b1;
                break;
            end
            if (ram_write) wcyc++;
            raddr = ram_address;
            @(posedge clk);
            #1;
        end
        if (!got) lat = 99;
        @(posedge clk);
        #1;
    endtask

    int          lat;
    int          wcyc;
    logic [31:0] rdata;
    logic [31:0] raddr;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        mem[3068] = 32'd7;
        mem[2001] = 32'd99;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_data  = '0;

        // Reset state
        #1;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_ram_write",  {31'd0, ram_write},  32'd0);
        chk("rst_resp_data",  resp_data,   32'd0);
        chk("rst_ram_address", ram_address, 32'd0);
        chk("rst_ram_data",   ram_data,    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Write 0 <- 14528
        xact(1'b1, 32'd0, 32'd14528, lat, rdata, wcyc, raddr);
        chk("wr0_latency", lat, 32'd3);
        chk("wr0_ram_write_cycles", wcyc, 32'd2);
        chk("wr0_ram_address", raddr, 32'd0);
        chk("wr0_resp_data", rdata, 32'd14528);
        chk("wr0_ram_content", mem[0], 32'd14528);

        // Read 0 -> hit
        xact(1'b0, 32'd0, 32'd0, lat, rdata, wcyc, raddr);
        chk("rd0_hit_latency", lat, 32'd1);
        chk("rd0_resp_data", rdata, 32'd14528);
        chk("rd0_no_ram_write", wcyc, 32'd0);

        // Write aliasing address, then read its 12-bit alias -> hit
        xact(1'b1, 32'd2816867292, 32'd526421, lat, rdata, wcyc, raddr);
        chk("wr_alias_latency", lat, 32'd3);
        chk("wr_alias_ram_address", raddr, 32'd3036);
        chk("wr_alias_resp_data", rdata, 32'd526421);
        xact(1'b0, 32'd3036, 32'd0, lat, rdata, wcyc, raddr);
        chk("rd3036_hit_latency", lat, 32'd1);
        chk("rd3036_resp_data", rdata, 32'd526421);

        // Conflict miss on index 28, then the evicted line misses
        xact(1'b0, 32'd3068, 32'd0, lat, rdata, wcyc, raddr);
        chk("rd3068_miss_latency", lat, 32'd3);
        chk("rd3068_ram_address", raddr, 32'd3068);
        chk("rd3068_resp_data", rdata, 32'd7);
        chk("rd3068_no_ram_write", wcyc, 32'd0);
        xact(1'b0, 32'd3036, 32'd0, lat, rdata, wcyc, raddr);
        chk("rd3036_evicted_latency", lat, 32'd3);
        chk("rd3036_refill_data", rdata, 32'd526421);

`ifdef CACHE_STATS_EN
        chk("hit_count", {16'd0, hit_count}, 32'd2);
        chk("miss_count", {16'd0, miss_count}, 32'd2);
`endif

        // Reset in the middle of a write to 2001
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'd2001;
        req_data  = 32'd555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_ram_write_active", {31'd0, ram_write}, 32'd1);
        chk("abort_ram_address", ram_address, 32'd2001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ram_write_drop", {31'd0, ram_write}, 32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_ram_address_cleared", ram_address, 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_ram_untouched", mem[2001], 32'd99);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready_after_reset", {31'd0, req_ready}, 32'd1);
`ifdef CACHE_STATS_EN
        chk("hit_count_reset", {16'd0, hit_count}, 32'd0);
`endif
        xact(1'b0, 32'd2001, 32'd0, lat, rdata, wcyc, raddr);
        chk("rd2001_miss_latency", lat, 32'd3);
        chk("rd2001_resp_data", rdata, 32'd99);

        // Earlier hit lines are gone after reset too
        xact(1'b0, 32'd0, 32'd0, lat, rdata, wcyc, raddr);
        chk("rd0_after_reset_miss", lat, 32'd3);
        chk("rd0_after_reset_data", rdata, 32'd14528);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
